// File: rtl/mac_array_sequencer_if.sv
// Job, FIFO and array-control signals between the job registers,
// the MAC array wrapper and the sequencer.
interface mac_array_sequencer_if #(
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int CNT_WIDTH          = 16
);
  logic                          start;
  logic                          abort;
  logic [1:0]                    operation;
  logic [4:0]                    kernel_size;
  logic [BRAM_ADDRESS_WIDTH-1:0] weight_base_addr;
  logic [CNT_WIDTH-1:0]          ifmap_beats;
  logic                          ifmaps_fifo_empty;

  logic                          bram_en;
  logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr;
  logic                          load_weight_preload;
  logic                          load_MAC_weight;
  logic                          load_ifmaps;
  logic                          pooling_compute;
  logic                          busy;
  logic                          done;
  logic                          cfg_error;

  modport master (
    output start, abort, operation, kernel_size, weight_base_addr, ifmap_beats,
           ifmaps_fifo_empty,
    input  bram_en, bram_addr, load_weight_preload, load_MAC_weight, load_ifmaps,
           pooling_compute, busy, done, cfg_error
  );

  modport slave (
    input  start, abort, operation, kernel_size, weight_base_addr, ifmap_beats,
           ifmaps_fifo_empty,
    output bram_en, bram_addr, load_weight_preload, load_MAC_weight, load_ifmaps,
           pooling_compute, busy, done, cfg_error
  );
endinterface

// File: rtl/mac_array_sequencer.sv
// Control sequencer for the MAC array: fetches kernel rows from weight BRAM,
// commits them to the MACs, then streams ifmap beats and reports completion.
module mac_array_sequencer #(
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int CNT_WIDTH          = 16
) (
  input logic                  clk,
  input logic                  rst,
  mac_array_sequencer_if.slave bus
);
  localparam int AW = BRAM_ADDRESS_WIDTH;

  typedef enum logic [2:0] {IDLE, W_FETCH, W_LATCH, W_COMMIT, STREAM, FINISH} state_t;

  state_t               state, state_next;
  logic                 pool_mode;
  logic [2:0]           k_q;
  logic [AW-1:0]        base_q;
  logic [CNT_WIDTH-1:0] beats_q;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic [2:0]           row_cnt;
  logic [2:0]           win_cnt;
  logic                 preload_q, pool_q, cfg_err_q;
  logic                 cfg_legal, accept_job, abort_hit;
  logic                 bram_en_c, load_mac_c, load_if_c;
  logic                 last_row, last_beat, win_full;

  assign cfg_legal  = (bus.kernel_size != 5'd0) && (bus.kernel_size <= 5'd5) &&
                      (bus.ifmap_beats != '0) && !bus.operation[0];
  assign accept_job = (state == IDLE) && bus.start && cfg_legal;
  assign abort_hit  = bus.abort && (state != IDLE);
  assign last_row   = row_cnt == (k_q - 3'd1);
  assign last_beat  = beat_cnt == (beats_q - CNT_WIDTH'(1));
  assign win_full   = (win_cnt + 3'd1) == k_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    bram_en_c  = 1'b0;
    load_mac_c = 1'b0;
    load_if_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept_job) state_next = bus.operation[1] ? STREAM : W_FETCH;
      end
      W_FETCH: begin
        bram_en_c = 1'b1;
        if (last_row) state_next = W_LATCH;
      end
      W_LATCH:  state_next = W_COMMIT;
      W_COMMIT: begin
        load_mac_c = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        load_if_c = ~bus.ifmaps_fifo_empty;
        if (load_if_c && last_beat) state_next = FINISH;
      end
      FINISH:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (abort_hit) state_next = IDLE;
  end

  // Registered strobes are squashed on abort so nothing fires after cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pool_mode <= 1'b0;
      k_q       <= '0;
      base_q    <= '0;
      beats_q   <= '0;
      row_cnt   <= '0;
      beat_cnt  <= '0;
      win_cnt   <= '0;
      preload_q <= 1'b0;
      pool_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      preload_q <= bram_en_c && !abort_hit;
      pool_q    <= 1'b0;
      cfg_err_q <= (state == IDLE) && bus.start && !cfg_legal;
      if (accept_job) begin
        pool_mode <= bus.operation[1];
        k_q       <= bus.kernel_size[2:0];
        base_q    <= bus.weight_base_addr;
        beats_q   <= bus.ifmap_beats;
        row_cnt   <= '0;
        beat_cnt  <= '0;
        win_cnt   <= '0;
      end else if (abort_hit || (state == FINISH)) begin
        row_cnt  <= '0;
        beat_cnt <= '0;
        win_cnt  <= '0;
      end else begin
        if (bram_en_c) row_cnt <= row_cnt + 3'd1;
        if (load_if_c) begin
          beat_cnt <= beat_cnt + CNT_WIDTH'(1);
          // A window closes on every K-th beat or on the final partial window.
          if (win_full || last_beat) begin
            win_cnt <= '0;
            pool_q  <= pool_mode;
          end else begin
            win_cnt <= win_cnt + 3'd1;
          end
        end
      end
    end
  end

  assign bus.bram_en             = bram_en_c;
  assign bus.bram_addr           = bram_en_c ? (base_q + AW'(row_cnt)) : '0;
  assign bus.load_weight_preload = preload_q;
  assign bus.load_MAC_weight     = load_mac_c;
  assign bus.load_ifmaps         = load_if_c;
  assign bus.pooling_compute     = pool_q;
  assign bus.busy                = state != IDLE;
  assign bus.done                = state == FINISH;
  assign bus.cfg_error           = cfg_err_q;
endmodule

// File: doc/mac_array_sequencer.md
Name: mac_array_sequencer

Overview:
- Control sequencer for the MAC array datapath wrapper.
- Per job, fetches kernel weights row-by-row from weight BRAM and pulses the preload shift strobe, then latches the weights into the MACs.
- Streams ifmap beats from the ifmap FIFO into the array, pulsing the load and pooling strobes, and reports completion.
- Sits between the AXI-lite job registers and the array wrapper; drives its load_weight_preload, load_MAC_weight, load_ifmaps and pooling_compute inputs.

Parameters:
- BRAM_ADDRESS_WIDTH, 12, weight BRAM address width.
- CNT_WIDTH, 16, width of the ifmap beat counter.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle job request; sampled only in IDLE.
- abort  input  1  synchronous job cancel.
- operation  input  2  2'b00 conv, 2'b10 pooling; 2'b01 and 2'b11 are illegal.
- kernel_size  input  5  K, legal range 1..5.
- weight_base_addr  input  BRAM_ADDRESS_WIDTH  BRAM address of kernel row 0.
- ifmap_beats  input  CNT_WIDTH  number of ifmap beats to stream; 0 is illegal.
- ifmaps_fifo_empty  input  1  ifmap FIFO empty flag.
- bram_en  output  1  weight BRAM read enable.
- bram_addr  output  BRAM_ADDRESS_WIDTH  weight BRAM read address.
- load_weight_preload  output  1  preload shift strobe; one per returned row.
- load_MAC_weight  output  1  one-cycle weight latch strobe.
- load_ifmaps  output  1  beat-accept strobe; doubles as the FIFO pop.
- pooling_compute  output  1  one-cycle pooling-window strobe.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse on normal completion.
- cfg_error  output  1  one-cycle pulse on an illegal start.

Behaviour:
- Reset: every output is 0, state is IDLE, all counters are 0.
- Job latch: operation, kernel_size, weight_base_addr and ifmap_beats are registered on an accepted start. Later input changes do not affect the running job.
- Legality check in IDLE:
  - An illegal start is K==0, K>5, ifmap_beats==0, or an illegal operation.
  - On an illegal start, cfg_error pulses the next cycle and the state stays IDLE.
  - start while busy is ignored, with no error.
- State W_FETCH (conv only, entered the cycle after start):
  - For row r = 0..K-1, one per cycle: bram_en=1, bram_addr=weight_base_addr+r.
  - Address arithmetic wraps modulo 2^BRAM_ADDRESS_WIDTH.
- BRAM read latency is 1 cycle. load_weight_preload is bram_en delayed by 1 cycle, giving exactly K pulses back-to-back.
- State W_LATCH: entered the cycle after the last bram_en. It coincides with the last load_weight_preload.
- State W_COMMIT: load_MAC_weight=1 for exactly one cycle, the cycle after the last preload pulse. Next state is STREAM.
- Pooling jobs skip W_FETCH, W_LATCH and W_COMMIT and go IDLE -> STREAM directly.
- State STREAM:
  - load_ifmaps = ~ifmaps_fifo_empty, combinationally in the same cycle.
  - The beat counter increments on each load_ifmaps.
  - FIFO-empty cycles stall the stream; there is no timeout.
- Pooling strobe: in pooling mode, pooling_compute pulses for one cycle registered after every K-th accepted beat. A final partial window (beats mod K != 0) also produces one pulse after the last beat.
  - In conv mode, pooling_compute is always 0.
- Stream end: after the beat with count == ifmap_beats-1 is accepted, the state goes to FINISH.
- State FINISH: done=1 for one cycle; busy stays high that cycle. Next state is IDLE.
  - A start in the FINISH cycle is ignored.
- abort:
  - Takes effect in any non-IDLE state: the next state is IDLE, all strobes deassert the next cycle, done is not pulsed, and counters clear.
  - abort in IDLE has no effect. abort and start together in IDLE: start wins.
- rst asserted mid-job: the asynchronous return to reset values happens immediately and no strobe completes.
- Mutual exclusion: bram_en, load_MAC_weight and load_ifmaps are never high in the same cycle.

Test Plan:
- Conv, K=3, base=0x010, beats=4, FIFO never empty:
  - bram_addr is 0x010/0x011/0x012 on cycles 1-3.
  - load_weight_preload is high on cycles 2-4.
  - load_MAC_weight is high on cycle 5.
  - load_ifmaps is high on cycles 6-9.
  - done is high on cycle 10; busy is high on cycles 1-10.
- Pooling, K=2, beats=5, FIFO empty on every other cycle:
  - Exactly 5 load_ifmaps pulses, each only while the FIFO is non-empty.
  - pooling_compute pulses after beats 2, 4 and 5.
  - No bram_en or load_MAC_weight pulse.
- Wrap: base=0xFFE, K=4:
  - bram_addr sequence is 0xFFE, 0xFFF, 0x000, 0x001.
- Illegal config, each in turn: K=0, K=6, beats=0, operation=2'b01:
  - cfg_error pulses once, busy stays 0, no strobes.
- abort during STREAM after 2 of 8 beats:
  - All strobes are 0 the next cycle, busy falls, no done.
  - A new start is then accepted normally.
- Async rst mid-W_FETCH, then a repeat start with K=5:
  - Outputs clear immediately on rst.
  - The new job issues exactly 5 fetches.
  - start pulses issued while busy are ignored.
